store_buffer: RTL and testbench
===============================

# store_buffer

Post-commit store queue that sits directly downstream of the write-back stage. The MEM stage pushes stores as they execute (uncommitted). The WB stage commits them in order through its store-commit enable, and an exception flush discards every uncommitted entry. Committed entries drain in program order to the dcache/uncache write port through an addr_ok/data_ok handshake, and the buffer reports load-address conflicts so the memory stage can stall dependent loads.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, 32: physical address width.
- DATA_W, 32: store data width; strobe width is DATA_W/8.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-high reset. The name is kept for consistency with the codebase; asserted means 1.
- push_valid_i  in  1  MEM store enqueue request.
- push_addr_i  in  ADDR_W  store physical address.
- push_data_i  in  DATA_W  store data, already lane-aligned.
- push_wstrb_i  in  DATA_W/8  byte strobes.
- push_uncache_i  in  1  store targets uncached space.
- full_o  out  1  no free entry; push is ignored while high.
- commit_i  in  1  WB store commit; driven by WB's store_buffer_ce_o.
- flush_i  in  1  WB exception flush; driven by excep_flush_o.
- wr_req_o  out  1  write request to the cache.
- wr_addr_o  out  ADDR_W  head entry address.
- wr_data_o  out  DATA_W  head entry data.
- wr_wstrb_o  out  DATA_W/8  head entry strobes.
- wr_uncache_o  out  1  head entry uncache flag.
- wr_addr_ok_i  in  1  cache accepted the request.
- wr_data_ok_i  in  1  cache completed the write.
- ld_addr_i  in  ADDR_W  address of the load currently in MEM.
- ld_conflict_o  out  1  load must stall.
- empty_o  out  1  no valid entry; used by ibar, dbar and ertn.

## Operation
- Circular array of DEPTH entries, each holding {valid, committed, addr, data, wstrb, uncache}.
- Pointers:
  - tail: next write location.
  - cmt: oldest uncommitted entry.
  - head: oldest entry.
- Each pointer is log2(DEPTH)+1 bits, with the MSB used as the wrap bit.
- full is true when tail and head differ only in the MSB. empty is true when tail equals head.
- Push: when push_valid_i is high, full_o is low and flush_i is low, write the entry at tail with committed=0 and advance tail.
- Commit: when commit_i is high and cmt differs from tail, set committed at cmt and advance cmt. A commit with no uncommitted entry is ignored and flagged by a simulation assertion.
- Flush: tail is set to cmt in the next-state computation, which drops all uncommitted entries including a same-cycle push. Committed entries are never affected.
- Same-cycle commit and flush: the commit is applied first, then the flush sets tail to the updated cmt.
- Drain FSM:
  - IDLE → REQ when the head entry is valid and committed.
  - REQ: wr_req_o is high and the wr_* outputs hold the head entry. REQ → WAIT on wr_addr_ok_i.
  - WAIT → IDLE on wr_data_ok_i; head is popped (valid cleared, head advanced) in that same cycle.
  - If wr_addr_ok_i and wr_data_ok_i arrive in the same REQ cycle, the FSM goes straight to IDLE and pops.
- Only one write is outstanding at a time.
- Outside WAIT, and in REQ before the address is accepted, wr_data_ok_i is ignored.
- A pop and a push in the same cycle are both honoured. full_o comes from registered pointers, so a pop does not free space for a same-cycle push.

## Timing
- Reset values:
  - all pointers 0, all valid bits 0, FSM in IDLE.
  - wr_req_o=0, wr_addr_o/wr_data_o/wr_wstrb_o/wr_uncache_o=0.
  - full_o=0, empty_o=1, ld_conflict_o=0.
- Reset asserted mid-transaction drops the request immediately. A data_ok arriving after reset is ignored.
- Latency:
  - push at cycle t, commit at cycle t+1: wr_req_o is high at t+2 at the earliest.
  - push and commit of different entries may occur in the same cycle.
  - A pop in cycle t allows wr_req_o for the next entry in cycle t+1.
- wr_req_o and the wr_* outputs are registered and stay stable while in REQ.
- full_o and empty_o are combinational from the registered pointers only.
- ld_conflict_o is combinational from ld_addr_i and the registered entries.

## Configuration
- STORE_BUF_LD_CHECK_EN defined: ld_conflict_o is high when any valid entry's address matches ld_addr_i in bits [ADDR_W-1:2] (word granularity, strobes ignored).
- STORE_BUF_LD_CHECK_EN undefined: ld_conflict_o equals ~empty_o, which conservatively stalls every load while the buffer holds data. No comparators are built.

## Structure
- A shared package/header holds:
  - the entry field layout and its width constant;
  - the FSM state encoding (IDLE, REQ, WAIT);
  - the bus-width macros for the push bundle and the cache-write bundle, consistent with the existing define header.
- One sub-module: store_buffer_match, holding the DEPTH-wide address comparators and OR-reduction. It is instantiated only when STORE_BUF_LD_CHECK_EN is defined.

## Test plan
- Basic drain: push addr 0x1c000100, data 0xdeadbeef, wstrb 0xf; commit next cycle; addr_ok 2 cycles later, then data_ok → exactly one write with those values, then empty_o=1.
- Full: 4 pushes with no commits → full_o=1. A 5th push is ignored. Commit all 4 and complete 4 writes → writes appear in push order with no loss.
- Flush: push A, B, C; commit A; flush_i together with a push of D → only A drains; B, C and D never reach wr_req_o; tail equals cmt.
- Commit and flush in the same cycle: entries A (uncommitted) and B, commit_i and flush_i together → A is written, B is dropped.
- Reset while in WAIT with 2 committed entries: assert rst_n=1 → wr_req_o=0 and empty_o=1. A late wr_data_ok_i causes no pop or underflow.
- Load check with the macro defined: entry at 0x1c000104, ld_addr_i=0x1c000106 → conflict=1; ld_addr_i=0x1c000108 → conflict=0. With the macro undefined → conflict=1 for both.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry layout, bus bundle widths and drain FSM encoding.
package store_buffer_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_STRB_W = SB_DATA_W / 8;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] wstrb;
        logic                 uncache;
    } sb_payload_t;

    typedef struct packed {
        logic        valid;
        logic        committed;
        sb_payload_t payload;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);
    // Push bundle carries the payload; the cache-write bundle adds the request bit on top.
    localparam int SB_PUSH_W  = $bits(sb_payload_t);
    localparam int SB_WR_W    = 1 + SB_PUSH_W;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_REQ,
        SB_WAIT
    } sb_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline/cache-facing signal bundle of the store buffer; slave is the buffer side, master the environment.
interface store_buffer_if #(
    parameter int ADDR_W = store_buffer_pkg::SB_ADDR_W,
    parameter int DATA_W = store_buffer_pkg::SB_DATA_W
);
    logic                  push_valid_i;
    logic [ADDR_W-1:0]     push_addr_i;
    logic [DATA_W-1:0]     push_data_i;
    logic [DATA_W/8-1:0]   push_wstrb_i;
    logic                  push_uncache_i;
    logic                  full_o;
    logic                  commit_i;
    logic                  flush_i;
    logic                  wr_req_o;
    logic [ADDR_W-1:0]     wr_addr_o;
    logic [DATA_W-1:0]     wr_data_o;
    logic [DATA_W/8-1:0]   wr_wstrb_o;
    logic                  wr_uncache_o;
    logic                  wr_addr_ok_i;
    logic                  wr_data_ok_i;
    logic [ADDR_W-1:0]     ld_addr_i;
    logic                  ld_conflict_o;
    logic                  empty_o;

    modport slave (
        input  push_valid_i, push_addr_i, push_data_i, push_wstrb_i, push_uncache_i,
        input  commit_i, flush_i, wr_addr_ok_i, wr_data_ok_i, ld_addr_i,
        output full_o, wr_req_o, wr_addr_o, wr_data_o, wr_wstrb_o, wr_uncache_o,
        output ld_conflict_o, empty_o
    );

    modport master (
        output push_valid_i, push_addr_i, push_data_i, push_wstrb_i, push_uncache_i,
        output commit_i, flush_i, wr_addr_ok_i, wr_data_ok_i, ld_addr_i,
        input  full_o, wr_req_o, wr_addr_o, wr_data_o, wr_wstrb_o, wr_uncache_o,
        input  ld_conflict_o, empty_o
    );
endinterface

// File: rtl/store_buffer_match.sv
// Word-granular comparators of the load address against every valid entry.
// Instantiated only when STORE_BUF_LD_CHECK_EN is defined.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = SB_ADDR_W - 2
) (
    input  logic [DEPTH-1:0]  valid,
    input  logic [WORD_W-1:0] entry_word [DEPTH],
    input  logic [WORD_W-1:0] ld_word,
    output logic              hit
);
    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] & (entry_word[i] == ld_word);
        end
    end

    assign hit = |match;

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: MEM pushes, WB commits or flushes, committed entries drain in order to the cache.
// STORE_BUF_LD_CHECK_EN enables per-entry load-address matching; without it every load stalls while non-empty.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave sb
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]   head_q, cmt_q, tail_q;
    logic [PTR_W-1:0]   head_d, cmt_d, tail_d;
    logic [DEPTH-1:0]   valid_q, valid_d, cmtd_q, cmtd_d;
    sb_payload_t        pl_q [DEPTH];
    sb_payload_t        push_pl, wr_pl;
    sb_entry_t          next_head;
    sb_state_e          state_q;
    logic [SB_WR_W-1:0] wr_q;
    logic               full, empty, push_en, commit_en, pop, load;

    assign full      = (tail_q ^ head_q) == {1'b1, {IDX_W{1'b0}}};
    assign empty     = (tail_q == head_q);
    assign push_en   = sb.push_valid_i & ~full & ~sb.flush_i;
    assign commit_en = sb.commit_i & (cmt_q != tail_q);
    assign pop       = sb.wr_data_ok_i &
                       ((state_q == SB_WAIT) | ((state_q == SB_REQ) & sb.wr_addr_ok_i));
    assign push_pl   = '{addr: sb.push_addr_i, data: sb.push_data_i,
                         wstrb: sb.push_wstrb_i, uncache: sb.push_uncache_i};

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        cmt_d   = cmt_q + PTR_W'(commit_en);
        tail_d  = sb.flush_i ? cmt_d : tail_q + PTR_W'(push_en);
        head_d  = head_q + PTR_W'(pop);
        valid_d = valid_q;
        cmtd_d  = cmtd_q;
        if (commit_en) cmtd_d[cmt_q[IDX_W-1:0]] = 1'b1;
        if (pop) begin
            valid_d[head_q[IDX_W-1:0]] = 1'b0;
            cmtd_d[head_q[IDX_W-1:0]]  = 1'b0;
        end
        // Flush sees this cycle's commit, so only entries still uncommitted are dropped.
        if (sb.flush_i) valid_d = valid_d & cmtd_d;
        if (push_en) begin
            valid_d[tail_q[IDX_W-1:0]] = 1'b1;
            cmtd_d[tail_q[IDX_W-1:0]]  = 1'b0;
        end
        next_head = '{valid: valid_d[head_d[IDX_W-1:0]], committed: cmtd_d[head_d[IDX_W-1:0]],
                      payload: pl_q[head_d[IDX_W-1:0]]};
        // Look ahead at the post-edge head so a commit or pop is followed by a request one cycle later.
        load = ((state_q == SB_IDLE) | pop) & next_head.valid & next_head.committed;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            cmtd_q  <= '0;
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            cmtd_q  <= cmtd_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push_en) pl_q[tail_q[IDX_W-1:0]] <= push_pl;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= SB_IDLE;
            wr_q    <= '0;
        end else begin
            case (state_q)
                SB_REQ: begin
                    if (sb.wr_addr_ok_i) begin
                        state_q           <= sb.wr_data_ok_i ? SB_IDLE : SB_WAIT;
                        wr_q[SB_WR_W-1]   <= 1'b0;
                    end
                end
                SB_WAIT: if (sb.wr_data_ok_i) state_q <= SB_IDLE;
                default: ;
            endcase
            if (load) begin
                state_q <= SB_REQ;
                wr_q    <= {1'b1, next_head.payload};
            end
        end
    end

    assign wr_pl           = wr_q[SB_PUSH_W-1:0];
    assign sb.wr_req_o     = wr_q[SB_WR_W-1];
    assign sb.wr_addr_o    = wr_pl.addr;
    assign sb.wr_data_o    = wr_pl.data;
    assign sb.wr_wstrb_o   = wr_pl.wstrb;
    assign sb.wr_uncache_o = wr_pl.uncache;
    assign sb.full_o       = full;
    assign sb.empty_o      = empty;

`ifdef STORE_BUF_LD_CHECK_EN
    logic [SB_ADDR_W-3:0] ent_word [DEPTH];
    logic                 ld_hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign ent_word[i] = pl_q[i].addr[SB_ADDR_W-1:2];
    end

    store_buffer_match #(
        .DEPTH  (DEPTH),
        .WORD_W (SB_ADDR_W - 2)
    ) u_match (
        .valid      (valid_q),
        .entry_word (ent_word),
        .ld_word    (sb.ld_addr_i[SB_ADDR_W-1:2]),
        .hit        (ld_hit)
    );

    assign sb.ld_conflict_o = ld_hit;
`else
    assign sb.ld_conflict_o = ~empty;
`endif

    commit_has_target: assert property (@(posedge clk) disable iff (rst_n)
        sb.commit_i |-> (cmt_q != tail_q));

endmodule

// File: tb/tb_store_buffer.sv
// Randomized self-checking bench for store_buffer against a queue-based model of the buffer contents.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
        logic        unc;
        bit          committed;
    } st_t;

    st_t         model[$];   // oldest first
    logic [31:0] wlog[$];    // addresses of completed writes
    bit          outstanding; // cache accepted the address, data_ok pending
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int n_uncommitted();
        int n = 0;
        foreach (model[i]) if (!model[i].committed) n++;
        return n;
    endfunction

    function automatic bit model_conflict(input logic [31:0] ld);
`ifdef STORE_BUF_LD_CHECK_EN
        foreach (model[i]) if (model[i].addr[31:2] == ld[31:2]) return 1'b1;
        return 1'b0;
`else
        return model.size() != 0;
`endif
    endfunction

    function automatic logic [31:0] rand_ld();
        if (model.size() > 0 && $urandom_range(0, 1) == 1)
            return {model[$urandom_range(0, model.size() - 1)].addr[31:2], 2'($urandom)};
        return 32'h1c000100 + $urandom_range(0, 63);
    endfunction

    task automatic drive_idle();
        bus.push_valid_i   = 1'b0;
        bus.push_addr_i    = '0;
        bus.push_data_i    = '0;
        bus.push_wstrb_i   = '0;
        bus.push_uncache_i = 1'b0;
        bus.commit_i       = 1'b0;
        bus.flush_i        = 1'b0;
        bus.wr_addr_ok_i   = 1'b0;
        bus.wr_data_ok_i   = 1'b0;
        bus.ld_addr_i      = '0;
    endtask

    // One clock: check outputs against the model, drive inputs, apply the rules at the rising edge.
    task automatic step(input bit push, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit u, input bit commit, input bit flush,
                        input bit aok, input bit dok, input logic [31:0] ld);
        bit req, exp_req, do_commit, push_ok, pop;
        bus.ld_addr_i = ld;
        #1;
        exp_req = model.size() > 0 && model[0].committed && !outstanding;
        check("wr_req", bus.wr_req_o, exp_req);
        if (exp_req && bus.wr_req_o) begin
            check("wr_addr", bus.wr_addr_o, model[0].addr);
            check("wr_data", bus.wr_data_o, model[0].data);
            check("wr_wstrb", bus.wr_wstrb_o, model[0].wstrb);
            check("wr_uncache", bus.wr_uncache_o, model[0].unc);
        end
        check("full", bus.full_o, model.size() == DEPTH);
        check("empty", bus.empty_o, model.size() == 0);
        check("ld_conflict", bus.ld_conflict_o, model_conflict(ld));
        req       = bus.wr_req_o;
        do_commit = commit && (n_uncommitted() > 0);
        push_ok   = push && (model.size() < DEPTH) && !flush;
        bus.push_valid_i   = push;
        bus.push_addr_i    = a;
        bus.push_data_i    = d;
        bus.push_wstrb_i   = s;
        bus.push_uncache_i = u;
        bus.commit_i       = do_commit;
        bus.flush_i        = flush;
        bus.wr_addr_ok_i   = aok;
        bus.wr_data_ok_i   = dok;
        @(posedge clk);
        pop = 1'b0;
        if (outstanding) begin
            if (dok) begin
                pop         = 1'b1;
                outstanding = 1'b0;
            end
        end else if (req && aok) begin
            if (dok) pop = 1'b1;
            else     outstanding = 1'b1;
        end
        if (do_commit) begin
            for (int i = 0; i < model.size(); i++) begin
                if (!model[i].committed) begin
                    model[i].committed = 1'b1;
                    break;
                end
            end
        end
        if (flush) while (model.size() > 0 && !model[model.size() - 1].committed) void'(model.pop_back());
        if (pop) begin
            check("pop_target", model.size() != 0, 1'b1);
            if (model.size() > 0) begin
                wlog.push_back(model[0].addr);
                void'(model.pop_front());
            end
        end
        if (push_ok) model.push_back('{addr: a, data: d, wstrb: s, unc: u, committed: 1'b0});
        @(negedge clk);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] d);
        step(1, a, d, 4'hf, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (model.size() > 0 && n < 200) begin
            step(0, 0, 0, 0, 0, 1, 0, 1, 1, rand_ld());
            n++;
        end
        check({tag, "_drained"}, model.size(), 0);
        nop();
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        check("rst_wr_req", bus.wr_req_o, 1'b0);
        check("rst_wr_addr", bus.wr_addr_o, 32'h0);
        check("rst_wr_data", bus.wr_data_o, 32'h0);
        check("rst_wr_wstrb", bus.wr_wstrb_o, 4'h0);
        check("rst_wr_uncache", bus.wr_uncache_o, 1'b0);
        check("rst_full", bus.full_o, 1'b0);
        check("rst_empty", bus.empty_o, 1'b1);
        check("rst_ld_conflict", bus.ld_conflict_o, 1'b0);
        model.delete();
        outstanding = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        outstanding = 1'b0;
        do_reset();

        // Basic drain with the earliest request two cycles after the push.
        wlog.delete();
        step(1, 32'h1c000100, 32'hdeadbeef, 4'hf, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        check("basic_req_latency", bus.wr_req_o, 1'b1);
        check("basic_addr", bus.wr_addr_o, 32'h1c000100);
        check("basic_data", bus.wr_data_o, 32'hdeadbeef);
        nop();
        nop();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        check("basic_writes", wlog.size(), 1);
        check("basic_empty", bus.empty_o, 1'b1);

        // Fill to capacity, overflow push is dropped, writes come out in push order.
        wlog.delete();
        for (int i = 0; i < DEPTH; i++) push1(32'h1c000200 + 4 * i, $urandom);
        check("full_after_fill", bus.full_o, 1'b1);
        push1(32'h1c000300, 32'h0badf00d);
        drain("full");
        check("full_writes", wlog.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("full_order%0d", i), (i < wlog.size()) ? wlog[i] : 32'hx, 32'h1c000200 + 4 * i);

        // Flush with a same-cycle push: only the committed entry survives.
        wlog.delete();
        push1(32'h1c000400, 32'h11111111);
        push1(32'h1c000404, 32'h22222222);
        push1(32'h1c000408, 32'h33333333);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        step(1, 32'h1c00040c, 32'h44444444, 4'hf, 0, 0, 1, 0, 0, 32'h0);
        drain("flush");
        check("flush_writes", wlog.size(), 1);
        check("flush_survivor", (wlog.size() > 0) ? wlog[0] : 32'hx, 32'h1c000400);

        // Commit and flush in one cycle: the commit lands first.
        wlog.delete();
        push1(32'h1c000500, 32'h55555555);
        push1(32'h1c000504, 32'h66666666);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0);
        drain("cmtflush");
        check("cmtflush_writes", wlog.size(), 1);
        check("cmtflush_survivor", (wlog.size() > 0) ? wlog[0] : 32'hx, 32'h1c000500);

        // Reset while a write is outstanding, then a stray data_ok.
        wlog.delete();
        push1(32'h1c000600, 32'h77777777);
        push1(32'h1c000604, 32'h88888888);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        check("late_dok_empty", bus.empty_o, 1'b1);
        check("late_dok_no_write", wlog.size(), 0);

        // Load conflict at word granularity.
        push1(32'h1c000104, 32'h99999999);
        bus.ld_addr_i = 32'h1c000106;
        #1;
        check("ld_same_word", bus.ld_conflict_o, 1'b1);
        bus.ld_addr_i = 32'h1c000108;
        #1;
`ifdef STORE_BUF_LD_CHECK_EN
        check("ld_next_word", bus.ld_conflict_o, 1'b0);
`else
        check("ld_next_word", bus.ld_conflict_o, 1'b1);
`endif
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 1)), 32'h1c000100 + $urandom_range(0, 63), $urandom,
                 4'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_ld());
        end
        drain("random");
        check("final_empty", bus.empty_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
